// File: rtl/itrx_aib_phy_jtag_pkg.sv
// Shared types and constants for the multi-channel AIB JTAG TAP.
package itrx_aib_phy_jtag_pkg;

    // IEEE 1149.1 TAP controller states
    typedef enum logic [3:0] {
        TAP_TLR      = 4'd0,
        TAP_RTI      = 4'd1,
        TAP_SEL_DR   = 4'd2,
        TAP_CAP_DR   = 4'd3,
        TAP_SHIFT_DR = 4'd4,
        TAP_EXIT1_DR = 4'd5,
        TAP_PAUSE_DR = 4'd6,
        TAP_EXIT2_DR = 4'd7,
        TAP_UPD_DR   = 4'd8,
        TAP_SEL_IR   = 4'd9,
        TAP_CAP_IR   = 4'd10,
        TAP_SHIFT_IR = 4'd11,
        TAP_EXIT1_IR = 4'd12,
        TAP_PAUSE_IR = 4'd13,
        TAP_EXIT2_IR = 4'd14,
        TAP_UPD_IR   = 4'd15
    } tapState_e;

    // Which data register sits between tdi and tdo
    typedef enum logic [2:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_CHSEL,
        DR_CTRL,
        DR_CHAIN
    } drSel_e;

    // Opcodes as plain integers; the top narrows them to its IR width.
    // BYPASS is all ones at whatever width the IR has.
    localparam int unsigned OPC_IDCODE       = 1;
    localparam int unsigned OPC_CHSEL        = 2;
    localparam int unsigned OPC_CTRL         = 3;
    localparam int unsigned OPC_AIB_SHIFT_EN = 12;

    // CTRL data register layout {rstn, rstn_en, weakpd, weakpu, intest, mode}
    localparam int unsigned CTRL_W       = 6;
    localparam int unsigned CTRL_MODE    = 0;
    localparam int unsigned CTRL_INTEST  = 1;
    localparam int unsigned CTRL_WEAKPU  = 2;
    localparam int unsigned CTRL_WEAKPD  = 3;
    localparam int unsigned CTRL_RSTN_EN = 4;
    localparam int unsigned CTRL_RSTN    = 5;

    // Channel controls come out of reset with only rstn high
    localparam logic [CTRL_W-1:0] CTRL_RST = 6'b100000;

    localparam int unsigned IDCODE_W = 32;

endpackage

// File: rtl/itrx_aib_phy_tapfsm.sv
// 16-state TAP controller with one-hot style decode strobes for the datapath.
module itrx_aib_phy_tapfsm
    import itrx_aib_phy_jtag_pkg::*;
(
    input  logic      tck_i,
    input  logic      rst_i,
    input  logic      tms_i,
    output tapState_e nextState_o,
    output logic      tlr_o,
    output logic      captureIr_o,
    output logic      shiftIr_o,
    output logic      updateIr_o,
    output logic      captureDr_o,
    output logic      shiftDr_o,
    output logic      updateDr_o
);

    tapState_e tapState_q;
    tapState_e tapState_d;

    // State register; reset parks the controller in Test-Logic-Reset
    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            tapState_q <= TAP_TLR;
        end else begin
            tapState_q <= tapState_d;
        end
    end

    // Next state depends only on the current state and tms, plus state decodes
    always_comb begin
        tapState_d  = tapState_q;
        tlr_o       = 1'b0;
        captureIr_o = 1'b0;
        shiftIr_o   = 1'b0;
        updateIr_o  = 1'b0;
        captureDr_o = 1'b0;
        shiftDr_o   = 1'b0;
        updateDr_o  = 1'b0;
        case (tapState_q)
            TAP_TLR:      tapState_d = tms_i ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      tapState_d = tms_i ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   tapState_d = tms_i ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   tapState_d = tms_i ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: tapState_d = tms_i ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: tapState_d = tms_i ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: tapState_d = tms_i ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: tapState_d = tms_i ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   tapState_d = tms_i ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:   tapState_d = tms_i ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   tapState_d = tms_i ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: tapState_d = tms_i ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: tapState_d = tms_i ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: tapState_d = tms_i ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: tapState_d = tms_i ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   tapState_d = tms_i ? TAP_SEL_DR   : TAP_RTI;
            default:      tapState_d = TAP_TLR;
        endcase
        tlr_o       = (tapState_q == TAP_TLR);
        captureIr_o = (tapState_q == TAP_CAP_IR);
        shiftIr_o   = (tapState_q == TAP_SHIFT_IR);
        updateIr_o  = (tapState_q == TAP_UPD_IR);
        captureDr_o = (tapState_q == TAP_CAP_DR);
        shiftDr_o   = (tapState_q == TAP_SHIFT_DR);
        updateDr_o  = (tapState_q == TAP_UPD_DR);
    end

    assign nextState_o = tapState_d;

endmodule

// File: rtl/itrx_aib_phy_jtag_mc.sv
// Multi-channel JTAG TAP: IDCODE, channel select, per-channel sticky controls
// and a scan chain built from only the selected AIB IO channels.
module itrx_aib_phy_jtag_mc
    import itrx_aib_phy_jtag_pkg::*;
#(
    parameter int unsigned       NUM_CH     = 4,
    parameter int unsigned       IR_WID     = 7,
    parameter logic [31:0]       IDCODE_VAL = 32'h0AB1_C0DF,
    parameter logic [NUM_CH-1:0] CHSEL_RST  = {NUM_CH{1'b1}}
) (
    input  logic              tck_i,
    input  logic              trst_or_por_rst_i,
    input  logic              tms_i,
    input  logic              tdi_i,
    output logic              tdo_o,
    output logic [NUM_CH-1:0] jtag_scan_in_o,
    input  logic [NUM_CH-1:0] jtag_scan_out_i,
    output logic [NUM_CH-1:0] jtag_clkdr_en_o,
    output logic [NUM_CH-1:0] jtag_scan_en_o,
    output logic [NUM_CH-1:0] jtag_mode_o,
    output logic [NUM_CH-1:0] jtag_intest_o,
    output logic [NUM_CH-1:0] jtag_weakpu_o,
    output logic [NUM_CH-1:0] jtag_weakpd_o,
    output logic [NUM_CH-1:0] jtag_rstn_en_o,
    output logic [NUM_CH-1:0] jtag_rstn_o
);

    localparam logic [IR_WID-1:0] OpBypass  = '1;
    localparam logic [IR_WID-1:0] OpIdcode  = IR_WID'(OPC_IDCODE);
    localparam logic [IR_WID-1:0] OpChsel   = IR_WID'(OPC_CHSEL);
    localparam logic [IR_WID-1:0] OpCtrl    = IR_WID'(OPC_CTRL);
    localparam logic [IR_WID-1:0] OpAibScan = IR_WID'(OPC_AIB_SHIFT_EN);
    localparam logic [IR_WID-1:0] IrCapture = {{(IR_WID-2){1'b0}}, 2'b01};

    tapState_e nextState;
    logic tlr, captureIr, shiftIr, updateIr, captureDr, shiftDr, updateDr;

    logic [IR_WID-1:0]                  irShift_q;
    logic [IR_WID-1:0]                  irLatched_q;
    logic                               bypass_q;
    logic [IDCODE_W-1:0]                idcode_q;
    logic [NUM_CH-1:0]                  chselShift_q;
    logic [CTRL_W-1:0]                  ctrlShift_q;
    logic [NUM_CH-1:0]                  chsel_q;
    logic [NUM_CH-1:0][CTRL_W-1:0]      ctrl_q;
    logic                               tdo_q;

    logic              isIdcode, isChsel, isCtrl, isAibScan, chainOn;
    drSel_e            drSel;
    logic [CTRL_W-1:0] ctrlCapture;
    logic              chainData;
    logic              drLsb;

    itrx_aib_phy_tapfsm u_tapfsm (
        .tck_i       (tck_i),
        .rst_i       (trst_or_por_rst_i),
        .tms_i       (tms_i),
        .nextState_o (nextState),
        .tlr_o       (tlr),
        .captureIr_o (captureIr),
        .shiftIr_o   (shiftIr),
        .updateIr_o  (updateIr),
        .captureDr_o (captureDr),
        .shiftDr_o   (shiftDr),
        .updateDr_o  (updateDr)
    );

    // Instruction shift register: fixed capture pattern, shifts right from tdi
    always_ff @(posedge tck_i) begin
        if (trst_or_por_rst_i) begin
            irShift_q <= IrCapture;
        end else if (captureIr) begin
            irShift_q <= IrCapture;
        end else if (shiftIr) begin
            irShift_q <= {tdi_i, irShift_q[IR_WID-1:1]};
        end
    end

    // Active instruction; falls back to IDCODE whenever the TAP sits in TLR
    always_ff @(posedge tck_i) begin
        if (trst_or_por_rst_i || tlr) begin
            irLatched_q <= OpIdcode;
        end else if (updateIr) begin
            irLatched_q <= irShift_q;
        end
    end

    // Instruction decode; unknown opcodes and an empty channel chain act as BYPASS
    always_comb begin
        isIdcode  = (irLatched_q == OpIdcode);
        isChsel   = (irLatched_q == OpChsel);
        isCtrl    = (irLatched_q == OpCtrl);
        isAibScan = (irLatched_q == OpAibScan) && (irLatched_q != OpBypass);
        chainOn   = isAibScan && (|chsel_q);
        if (isIdcode) begin
            drSel = DR_IDCODE;
        end else if (isChsel) begin
            drSel = DR_CHSEL;
        end else if (isCtrl) begin
            drSel = DR_CTRL;
        end else if (chainOn) begin
            drSel = DR_CHAIN;
        end else begin
            drSel = DR_BYPASS;
        end
    end

    // CTRL capture reads back the lowest-index selected channel, zero if none
    always_comb begin
        ctrlCapture = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (chsel_q[i]) begin
                ctrlCapture = ctrl_q[i];
            end
        end
    end

    // Internal data registers: capture and shift whichever one is selected
    always_ff @(posedge tck_i) begin
        if (trst_or_por_rst_i) begin
            bypass_q     <= 1'b0;
            idcode_q     <= IDCODE_VAL;
            chselShift_q <= CHSEL_RST;
            ctrlShift_q  <= CTRL_RST;
        end else if (captureDr) begin
            case (drSel)
                DR_BYPASS: bypass_q     <= 1'b0;
                DR_IDCODE: idcode_q     <= IDCODE_VAL;
                DR_CHSEL:  chselShift_q <= chsel_q;
                DR_CTRL:   ctrlShift_q  <= ctrlCapture;
                default:   ;
            endcase
        end else if (shiftDr) begin
            case (drSel)
                DR_BYPASS: bypass_q     <= tdi_i;
                DR_IDCODE: idcode_q     <= {tdi_i, idcode_q[IDCODE_W-1:1]};
                DR_CHSEL:  chselShift_q <= {tdi_i, chselShift_q[NUM_CH-1:1]};
                DR_CTRL:   ctrlShift_q  <= {tdi_i, ctrlShift_q[CTRL_W-1:1]};
                default:   ;
            endcase
        end
    end

    // Channel select survives TLR so a chain setup persists across TAP resets
    always_ff @(posedge tck_i) begin
        if (trst_or_por_rst_i) begin
            chsel_q <= CHSEL_RST;
        end else if (updateDr && (drSel == DR_CHSEL)) begin
            chsel_q <= chselShift_q;
        end
    end

    // Sticky per-channel controls; an update only touches selected channels
    always_ff @(posedge tck_i) begin
        if (trst_or_por_rst_i || tlr) begin
            ctrl_q <= {NUM_CH{CTRL_RST}};
        end else if (updateDr && (drSel == DR_CTRL)) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (chsel_q[i]) begin
                    ctrl_q[i] <= ctrlShift_q;
                end
            end
        end
    end

    // Stitch selected channels in ascending order; chainData ends as the chain tail
    always_comb begin
        chainData      = tdi_i;
        jtag_scan_in_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (isAibScan && chsel_q[i]) begin
                jtag_scan_in_o[i] = chainData;
                chainData         = jtag_scan_out_i[i];
            end
        end
    end

    // LSB of the active internal register feeding the falling-edge tdo flop
    always_comb begin
        case (drSel)
            DR_IDCODE: drLsb = idcode_q[0];
            DR_CHSEL:  drLsb = chselShift_q[0];
            DR_CTRL:   drLsb = ctrlShift_q[0];
            DR_CHAIN:  drLsb = tdo_q;
            default:   drLsb = bypass_q;
        endcase
    end

    // tdo changes on the falling edge so the host samples it cleanly on the rising edge
    always_ff @(negedge tck_i) begin
        if (trst_or_por_rst_i) begin
            tdo_q <= 1'b0;
        end else if (shiftIr) begin
            tdo_q <= irShift_q[0];
        end else if (shiftDr) begin
            tdo_q <= drLsb;
        end
    end

    // Chain tail drives tdo directly; the channels already retime their own data
    always_comb begin
        tdo_o = (chainOn && !shiftIr) ? chainData : tdo_q;
        jtag_scan_en_o  = chsel_q & {NUM_CH{isAibScan && shiftDr}};
        jtag_clkdr_en_o = chsel_q & {NUM_CH{isAibScan && (nextState == TAP_SHIFT_DR)}};
    end

    // Fan the per-channel control words out to their individual pins
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            jtag_mode_o[i]    = ctrl_q[i][CTRL_MODE];
            jtag_intest_o[i]  = ctrl_q[i][CTRL_INTEST];
            jtag_weakpu_o[i]  = ctrl_q[i][CTRL_WEAKPU];
            jtag_weakpd_o[i]  = ctrl_q[i][CTRL_WEAKPD];
            jtag_rstn_en_o[i] = ctrl_q[i][CTRL_RSTN_EN];
            jtag_rstn_o[i]    = ctrl_q[i][CTRL_RSTN];
        end
    end

endmodule
